wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 115 +++++++++++
 tb/tb_wb_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Y86-64 SEQ writeback stage: destination decode, 15-entry register file with
// two combinational read ports, sticky processor status and retired count.
module wb_regfile #(
    parameter int         NREG  = 15,
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RSP   = 4'h4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic        instr_valid,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA_rd,
    output logic [63:0] valB_rd,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] instret
);

    // State encodings double as the architectural stat codes.
    typedef enum logic [2:0] {
        ST_RUN = 3'd1,
        ST_HLT = 3'd2,
        ST_ADR = 3'd3,
        ST_INS = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      cls;
    logic [63:0] regs_reg [NREG];
    logic [63:0] instret_reg;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        live;
    logic        commit;
    logic        retire;

    always_comb begin
        dst_e = RNONE;
        case (icode)
            4'h2:                   dst_e = cnd ? rB : RNONE;
            4'h3, 4'h6:             dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
            default:                dst_e = RNONE;
        endcase
        dst_m = (icode == 4'h5 || icode == 4'hB) ? rA : RNONE;
    end

    always_comb begin
        if (imem_error || dmem_error)
            cls = ST_ADR;
        else if (!instr_valid)
            cls = ST_INS;
        else if (icode == 4'h0)
            cls = ST_HLT;
        else
            cls = ST_RUN;
    end

    assign live   = (state_reg == ST_RUN) && valid;
    assign commit = live && (cls == ST_RUN);
    assign retire = live && (cls == ST_RUN || cls == ST_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            instret_reg <= 64'd0;
        end else begin
            if (live)
                state_reg <= cls;
            if (retire)
                instret_reg <= instret_reg + 64'd1;
        end
    end

    // dstM is tested first so that popq %rsp leaves the popped value in %rsp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs_reg[i] <= 64'd0;
        end else if (commit) begin
            for (int i = 0; i < NREG; i++) begin
                if (dst_m == 4'(i))
                    regs_reg[i] <= valM;
                else if (dst_e == 4'(i))
                    regs_reg[i] <= valE;
            end
        end
    end

    always_comb begin
        valA_rd = 64'd0;
        valB_rd = 64'd0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i))
                valA_rd = regs_reg[i];
            if (srcB == 4'(i))
                valB_rd = regs_reg[i];
        end
    end

    assign stat    = state_reg;
    assign halted  = (state_reg != ST_RUN);
    assign instret = instret_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// instruction stream checked against an architectural model.
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA, rB;
    logic [63:0] valE, valM;
    logic        imem_error, dmem_error, instr_valid;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA_rd, valB_rd;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model
    logic [63:0] m_reg [15];
    logic [2:0]  m_stat;
    logic [63:0] m_instret;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .icode(icode), .cnd(cnd),
        .rA(rA), .rB(rB), .valE(valE), .valM(valM),
        .imem_error(imem_error), .dmem_error(dmem_error), .instr_valid(instr_valid),
        .srcA(srcA), .srcB(srcB), .valA_rd(valA_rd), .valB_rd(valB_rd),
        .stat(stat), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic c, input logic [3:0] b);
        if (ic == 4'h2) return c ? b : 4'hF;
        if (ic == 4'h3 || ic == 4'h6) return b;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] a);
        return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
        m_stat    = 3'd1;
        m_instret = 64'd0;
    endtask

    task automatic model_apply();
        logic [3:0] e, m;
        if (m_stat != 3'd1 || !valid) return;
        if (imem_error || dmem_error) m_stat = 3'd3;
        else if (!instr_valid) m_stat = 3'd4;
        else if (icode == 4'h0) begin
            m_stat    = 3'd2;
            m_instret = m_instret + 64'd1;
        end else begin
            e = f_dst_e(icode, cnd, rB);
            m = f_dst_m(icode, rA);
            if (e != 4'hF) m_reg[e] = valE;
            if (m != 4'hF) m_reg[m] = valM;
            m_instret = m_instret + 64'd1;
        end
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                             input logic [63:0] e, input logic [63:0] m, input logic c);
        valid = 1'b1; icode = ic; rA = a; rB = b; valE = e; valM = m; cnd = c;
        imem_error = 1'b0; dmem_error = 1'b0; instr_valid = 1'b1;
    endtask

    // Update the model, clock the DUT, land 1ns after the edge.
    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
        $display("txn t=%0t v=%0b ic=%h rA=%h rB=%h cnd=%0b valE=%h valM=%h -> stat=%0d instret=%0d",
                 $time, valid, icode, rA, rB, cnd, valE, valM, stat, instret);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; icode = 4'h1; cnd = 1'b0; rA = 4'hF; rB = 4'hF;
        valE = '0; valM = '0; imem_error = 1'b0; dmem_error = 1'b0; instr_valid = 1'b1;
        srcA = 4'h0; srcB = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (stat !== 3'd1) begin n_err++; $display("FAIL reset_stat: got %0d expected 1", stat); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i); srcB = 4'(14 - i); #1;
            n_cmp++; if (valA_rd !== 64'd0 || valB_rd !== 64'd0) begin
                n_err++; $display("FAIL reset_read r%0d: got %h/%h expected 0", i, valA_rd, valB_rd);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        set_instr(4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 1'b0);
        tick();
        valid = 1'b0; srcA = 4'h2; #1;
        n_cmp++; if (valA_rd !== 64'h1234) begin n_err++; $display("FAIL irmovq_r2: got %h expected 1234", valA_rd); end
        n_cmp++; if (instret !== 64'd1) begin n_err++; $display("FAIL irmovq_instret: got %0d expected 1", instret); end
        n_cmp++; if (stat !== 3'd1) begin n_err++; $display("FAIL irmovq_stat: got %0d expected 1", stat); end
    endtask

    task automatic test_cmov();
        set_instr(4'h2, 4'h1, 4'h5, 64'd7, 64'h0, 1'b0);
        tick();
        srcB = 4'h5; #1;
        n_cmp++; if (valB_rd !== 64'd0) begin n_err++; $display("FAIL cmov_notaken: got %h expected 0", valB_rd); end
        set_instr(4'h2, 4'h1, 4'h5, 64'd7, 64'h0, 1'b1);
        tick();
        #1;
        n_cmp++; if (valB_rd !== 64'd7) begin n_err++; $display("FAIL cmov_taken: got %h expected 7", valB_rd); end
        n_cmp++; if (instret !== m_instret) begin n_err++; $display("FAIL cmov_instret: got %0d expected %0d", instret, m_instret); end
    endtask

    task automatic test_popq_rsp();
        set_instr(4'hB, 4'h4, 4'hF, 64'h108, 64'hBEEF, 1'b0);
        tick();
        srcA = 4'h4; #1;
        n_cmp++; if (valA_rd !== 64'hBEEF) begin n_err++; $display("FAIL popq_rsp: got %h expected beef", valA_rd); end
    endtask

    task automatic test_read_during_write();
        set_instr(4'h3, 4'hF, 4'h3, 64'd1, 64'h0, 1'b0);
        tick();
        set_instr(4'h6, 4'h0, 4'h3, 64'd9, 64'h0, 1'b0);
        srcA = 4'h3; #1;
        n_cmp++; if (valA_rd !== 64'd1) begin n_err++; $display("FAIL rdw_before: got %h expected 1", valA_rd); end
        tick();
        n_cmp++; if (valA_rd !== 64'd9) begin n_err++; $display("FAIL rdw_after: got %h expected 9", valA_rd); end
    endtask

    task automatic test_random();
        logic [3:0] sa, sb;
        for (int n = 0; n < 200; n++) begin
            set_instr(4'($urandom_range(1, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            valid = ($urandom_range(0, 3) != 0);
            tick();
            sa = 4'($urandom_range(0, 15)); sb = 4'($urandom_range(0, 15));
            srcA = sa; srcB = sb; #1;
            n_cmp++; if (valA_rd !== ((sa == 4'hF) ? 64'd0 : m_reg[sa])) begin
                n_err++; $display("FAIL rand_valA r%0d: got %h expected %h", sa, valA_rd, (sa == 4'hF) ? 64'd0 : m_reg[sa]);
            end
            n_cmp++; if (valB_rd !== ((sb == 4'hF) ? 64'd0 : m_reg[sb])) begin
                n_err++; $display("FAIL rand_valB r%0d: got %h expected %h", sb, valB_rd, (sb == 4'hF) ? 64'd0 : m_reg[sb]);
            end
            n_cmp++; if (instret !== m_instret || stat !== m_stat) begin
                n_err++; $display("FAIL rand_status: got stat=%0d instret=%0d expected stat=%0d instret=%0d", stat, instret, m_stat, m_instret);
            end
        end
    endtask

    task automatic test_fault();
        set_instr(4'h4, 4'h1, 4'h2, 64'h55, 64'h66, 1'b0);
        dmem_error = 1'b1; instr_valid = 1'b0;
        tick();
        n_cmp++; if (stat !== 3'd3) begin n_err++; $display("FAIL fault_stat: got %0d expected 3", stat); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL fault_halted: got %0b expected 1", halted); end
        for (int n = 0; n < 6; n++) begin
            set_instr(4'h6, 4'h0, 4'($urandom_range(0, 14)), {$urandom, $urandom}, 64'h0, 1'b0);
            tick();
        end
        n_cmp++; if (stat !== 3'd3 || instret !== m_instret) begin
            n_err++; $display("FAIL fault_sticky: got stat=%0d instret=%0d expected 3/%0d", stat, instret, m_instret);
        end
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i); #1;
            n_cmp++; if (valA_rd !== m_reg[i]) begin n_err++; $display("FAIL fault_reg r%0d: got %h expected %h", i, valA_rd, m_reg[i]); end
        end
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        // Instruction-invalid fault from a clean start
        set_instr(4'h6, 4'h0, 4'h1, 64'h77, 64'h0, 1'b0);
        instr_valid = 1'b0;
        tick();
        srcA = 4'h1; #1;
        n_cmp++; if (stat !== 3'd4 || valA_rd !== 64'd0 || instret !== 64'd0) begin
            n_err++; $display("FAIL ins_fault: got stat=%0d r1=%h instret=%0d expected 4/0/0", stat, valA_rd, instret);
        end
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_halt();
        set_instr(4'h3, 4'hF, 4'h7, 64'hABCD, 64'h0, 1'b0);
        tick();
        set_instr(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        tick();
        n_cmp++; if (stat !== 3'd2 || halted !== 1'b1) begin n_err++; $display("FAIL halt_stat: got %0d/%0b expected 2/1", stat, halted); end
        n_cmp++; if (instret !== m_instret) begin n_err++; $display("FAIL halt_instret: got %0d expected %0d", instret, m_instret); end
        srcA = 4'h7; #1;
        rst_n = 1'b0; model_reset();
        #1;
        n_cmp++; if (stat !== 3'd1 || halted !== 1'b0 || instret !== 64'd0) begin
            n_err++; $display("FAIL async_reset: got stat=%0d halted=%0b instret=%0d expected 1/0/0", stat, halted, instret);
        end
        n_cmp++; if (valA_rd !== 64'd0) begin n_err++; $display("FAIL async_reset_r7: got %h expected 0", valA_rd); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq_rsp();
        test_read_during_write();
        test_random();
        test_fault();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
